kernel_dispatch: RTL and testbench

KERNEL_DISPATCH -- requirements
Module: kernel_dispatch

---
 rtl/gpu_dispatch_pkg.sv | 21 ++
 rtl/kernel_dispatch_slot.sv | 87 ++++++++
 rtl/kernel_dispatch.sv | 180 ++++++++++++++++++
 tb/tb_kernel_dispatch.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_dispatch_pkg.sv
// rtl/gpu_dispatch_pkg.sv - shared state encodings for the kernel dispatcher
// Purpose: top-level dispatcher FSM states and per-core slot lifecycle states.
package gpu_dispatch_pkg;

    // Kernel-level lifecycle.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_DONE
    } disp_state_e;

    // Per-core lifecycle: FREE (idle, no pulse), RESET (core_reset high this
    // cycle), ACTIVE (core_start high, waiting for core_done).
    typedef enum logic [1:0] {
        SLOT_FREE,
        SLOT_RESET,
        SLOT_ACTIVE
    } slot_state_e;

endpackage

// File: rtl/kernel_dispatch_slot.sv
// rtl/kernel_dispatch_slot.sv - per-core block lifecycle (reset pulse, run, completion)
// Purpose: owns one core's start/reset/block-id/thread-count registers.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   kill_i              force a one-cycle reset pulse and drop core_start (launch/abort)
//   grant_i, grant_*_i  block assignment from the parent allocator
//   core_done_i         core's block-complete flag
//   core_*_o            registered per-core outputs
//   idle_o              slot can accept a block at the next edge
//   done_evt_o          a completion is being accepted this cycle
module kernel_dispatch_slot
    import gpu_dispatch_pkg::*;
#(
    parameter int TCB = 16,
    parameter int CW  = 3
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           kill_i,
    input  logic           grant_i,
    input  logic [TCB-1:0] grant_id_i,
    input  logic [CW-1:0]  grant_cnt_i,
    input  logic           core_done_i,
    output logic           core_start_o,
    output logic           core_reset_o,
    output logic [TCB-1:0] block_id_o,
    output logic [CW-1:0]  thread_count_o,
    output logic           idle_o,
    output logic           done_evt_o
);

    slot_state_e    state_q;
    logic           start_q;
    logic           reset_q;
    logic [TCB-1:0] id_q;
    logic [CW-1:0]  cnt_q;

    // Reset leaves the slot in RESET so core_reset drops on the first edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SLOT_RESET;
            start_q <= 1'b0;
            reset_q <= 1'b1;
            id_q    <= '0;
            cnt_q   <= '0;
        end else if (kill_i) begin
            state_q <= SLOT_RESET;
            start_q <= 1'b0;
            reset_q <= 1'b1;
        end else begin
            case (state_q)
                SLOT_FREE, SLOT_RESET: begin
                    reset_q <= 1'b0;
                    if (grant_i) begin
                        state_q <= SLOT_ACTIVE;
                        start_q <= 1'b1;
                        id_q    <= grant_id_i;
                        cnt_q   <= grant_cnt_i;
                    end else begin
                        state_q <= SLOT_FREE;
                    end
                end
                SLOT_ACTIVE: begin
                    // Assignment stays frozen until the core reports completion.
                    if (core_done_i) begin
                        state_q <= SLOT_RESET;
                        start_q <= 1'b0;
                        reset_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= SLOT_FREE;
                    start_q <= 1'b0;
                    reset_q <= 1'b0;
                end
            endcase
        end
    end

    assign core_start_o   = start_q;
    assign core_reset_o   = reset_q;
    assign block_id_o     = id_q;
    assign thread_count_o = cnt_q;
    assign idle_o         = (state_q != SLOT_ACTIVE);
    assign done_evt_o     = (state_q == SLOT_ACTIVE) && core_done_i;

endmodule

// File: rtl/kernel_dispatch.sv
// rtl/kernel_dispatch.sv - kernel launcher distributing thread blocks over compute cores
// Purpose: latches a kernel size on a start edge, hands blocks to idle cores in
// ascending order, counts completions and reports done.
// Ports:
//   clk, reset (async, active-low), start (edge), abort (level), thread_count
//   core_done                 per-core completion flags
//   core_start, core_reset    per-core run request / reset pulse
//   core_block_id             per-core block id (flat, core i at [i*TCB +: TCB])
//   core_thread_count         per-core active threads (flat, core i at [i*CW +: CW])
//   busy, done                kernel running / kernel finished
module kernel_dispatch
    import gpu_dispatch_pkg::*;
#(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_COUNT_BITS = 16
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              start,
    input  logic                                              abort,
    input  logic [THREAD_COUNT_BITS-1:0]                      thread_count,
    input  logic [NUM_CORES-1:0]                              core_done,
    output logic [NUM_CORES-1:0]                              core_start,
    output logic [NUM_CORES-1:0]                              core_reset,
    output logic [NUM_CORES*THREAD_COUNT_BITS-1:0]            core_block_id,
    output logic [NUM_CORES*($clog2(THREADS_PER_BLOCK)+1)-1:0] core_thread_count,
    output logic                                              busy,
    output logic                                              done
);

    localparam int             TCB    = THREAD_COUNT_BITS;
    localparam int             LOG2   = $clog2(THREADS_PER_BLOCK);
    localparam int             CW     = LOG2 + 1;
    localparam logic [TCB:0]   TPB_M1 = (TCB+1)'(THREADS_PER_BLOCK - 1);
    localparam logic [TCB-1:0] TPB_W  = TCB'(THREADS_PER_BLOCK);
    localparam logic [CW-1:0]  TPB_C  = CW'(THREADS_PER_BLOCK);

    disp_state_e    state_q;
    logic           start_q, armed_q, busy_q, done_q;
    logic [TCB-1:0] tc_q, total_q, next_block_q, blocks_done_q;
    logic [TCB-1:0] next_block_d, blocks_done_d;

    logic [TCB:0]   tc_round;
    logic [TCB-1:0] total_w;
    logic           start_edge, in_flight, abort_go, launch_go, alloc_en, kill;

    logic [NUM_CORES-1:0] grant, slot_idle, done_evt;
    logic [TCB-1:0]       grant_id  [NUM_CORES];
    logic [CW-1:0]        grant_cnt [NUM_CORES];
    logic [TCB-1:0]       alloc_nb, alloc_rem;

    // ceil(thread_count / THREADS_PER_BLOCK), one extra bit so the round-up cannot wrap.
    assign tc_round = {1'b0, thread_count} + TPB_M1;
    assign total_w  = TCB'(tc_round >> LOG2);

    // armed_q masks the first edge after reset so a start held through reset is not taken.
    assign start_edge = start && !start_q && armed_q;
    assign in_flight  = (state_q == ST_LAUNCH) || (state_q == ST_RUN);
    assign abort_go   = abort && in_flight;
    assign launch_go  = start_edge && !abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign alloc_en   = in_flight && !abort;
    assign kill       = abort_go || launch_go;

    // Ordered allocator: walking cores in ascending index gives ascending block ids.
    always_comb begin
        alloc_nb  = next_block_q;
        alloc_rem = '0;
        grant     = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            grant_id[i]  = '0;
            grant_cnt[i] = '0;
            if (alloc_en && slot_idle[i] && (alloc_nb < total_q)) begin
                alloc_rem    = tc_q - (alloc_nb << LOG2);
                grant[i]     = 1'b1;
                grant_id[i]  = alloc_nb;
                grant_cnt[i] = (alloc_rem >= TPB_W) ? TPB_C : alloc_rem[CW-1:0];
                alloc_nb     = alloc_nb + 1'b1;
            end
        end
        next_block_d = alloc_nb;
    end

    always_comb begin
        blocks_done_d = blocks_done_q;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (done_evt[i]) begin
                blocks_done_d = blocks_done_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            start_q       <= 1'b0;
            armed_q       <= 1'b0;
            tc_q          <= '0;
            total_q       <= '0;
            next_block_q  <= '0;
            blocks_done_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            start_q <= start;
            armed_q <= 1'b1;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                    end else if (start_edge) begin
                        state_q       <= ST_LAUNCH;
                        tc_q          <= thread_count;
                        total_q       <= total_w;
                        next_block_q  <= '0;
                        blocks_done_q <= '0;
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                    end
                end
                ST_LAUNCH: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else begin
                        // Slots leave their launch reset pulse and take blocks on this edge.
                        state_q      <= ST_RUN;
                        next_block_q <= next_block_d;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else if (blocks_done_q == total_q) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        next_block_q  <= next_block_d;
                        blocks_done_q <= blocks_done_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
        kernel_dispatch_slot #(
            .TCB(TCB),
            .CW (CW)
        ) u_slot (
            .clk_i         (clk),
            .rst_ni        (reset),
            .kill_i        (kill),
            .grant_i       (grant[g]),
            .grant_id_i    (grant_id[g]),
            .grant_cnt_i   (grant_cnt[g]),
            .core_done_i   (core_done[g]),
            .core_start_o  (core_start[g]),
            .core_reset_o  (core_reset[g]),
            .block_id_o    (core_block_id[g*TCB +: TCB]),
            .thread_count_o(core_thread_count[g*CW +: CW]),
            .idle_o        (slot_idle[g]),
            .done_evt_o    (done_evt[g])
        );
    end

endmodule

// File: tb/tb_kernel_dispatch.sv
// tb/tb_kernel_dispatch.sv - self-checking bench for kernel_dispatch
module tb_kernel_dispatch;

    localparam int NC  = 2;
    localparam int TPB = 4;
    localparam int TCB = 16;
    localparam int CW  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [TCB-1:0]    thread_count;
    logic [NC-1:0]     core_done;
    logic [NC-1:0]     core_start;
    logic [NC-1:0]     core_reset;
    logic [NC*TCB-1:0] core_block_id;
    logic [NC*CW-1:0]  core_thread_count;
    logic              busy;
    logic              done;

    int errors = 0;
    int checks = 0;

    kernel_dispatch #(
        .NUM_CORES        (NC),
        .THREADS_PER_BLOCK(TPB),
        .THREAD_COUNT_BITS(TCB)
    ) dut (
        .clk              (clk),
        .reset            (rst_n),
        .start            (start),
        .abort            (abort),
        .thread_count     (thread_count),
        .core_done        (core_done),
        .core_start       (core_start),
        .core_reset       (core_reset),
        .core_block_id    (core_block_id),
        .core_thread_count(core_thread_count),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    // Reference model: plain arithmetic on the block partition.
    function automatic int exp_blocks(input int tc);
        return (tc + TPB - 1) / TPB;
    endfunction

    function automatic int exp_cnt(input int tc, input int id);
        int r;
        r = tc - id * TPB;
        return (r < TPB) ? r : TPB;
    endfunction

    function automatic int bid(input int i);
        return int'(core_block_id[i*TCB +: TCB]);
    endfunction

    function automatic int cnt(input int i);
        return int'(core_thread_count[i*CW +: CW]);
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic launch(input int tc);
        start        = 1'b1;
        thread_count = TCB'(tc);
        tick();
        start        = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b1; abort = 1'b0; core_done = '0; thread_count = 16'd8;
        #12;
        checks++;
        if ({core_start, core_reset, busy, done} !== 6'b00_11_0_0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 001100", {core_start, core_reset, busy, done});
        end
        checks++;
        if ({core_block_id, core_thread_count} !== '0) begin
            errors++; $display("FAIL reset_data: got %h want 0", {core_block_id, core_thread_count});
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({core_reset, busy} !== 3'b00_0) begin
            errors++; $display("FAIL reset_release: got %b want 000", {core_reset, busy});
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL held_start_ignored: busy got %b want 0", busy);
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        launch(8);
        checks++;
        if ({core_start, core_reset, busy, done} !== 6'b00_11_1_0) begin
            errors++; $display("FAIL basic_launch: got %b want 001110", {core_start, core_reset, busy, done});
        end
        tick();
        checks++;
        if ({core_start, core_reset} !== 4'b11_00 || bid(0) != 0 || bid(1) != 1 ||
            cnt(0) != exp_cnt(8, 0) || cnt(1) != exp_cnt(8, 1)) begin
            errors++; $display("FAIL basic_assign: start=%b rst=%b id=%0d,%0d cnt=%0d,%0d want 11 00 0,1 4,4",
                               core_start, core_reset, bid(0), bid(1), cnt(0), cnt(1));
        end
        tick();
        core_done = 2'b01; tick(); core_done = '0;
        checks++;
        if ({core_start, core_reset} !== 4'b10_01) begin
            errors++; $display("FAIL basic_c0_done: got %b want 1001", {core_start, core_reset});
        end
        tick();
        checks++;
        if ({core_start, core_reset, bid(1) == 1} !== 5'b10_00_1) begin
            errors++; $display("FAIL basic_c0_free: got %b want 10001", {core_start, core_reset, bid(1) == 1});
        end
        core_done = 2'b10; tick(); core_done = '0;
        checks++;
        if ({core_start, busy, done} !== 4'b00_1_0) begin
            errors++; $display("FAIL basic_pre_done: got %b want 0010", {core_start, busy, done});
        end
        tick();
        checks++;
        if ({busy, done} !== 2'b01) begin
            errors++; $display("FAIL basic_done: got %b want 01", {busy, done});
        end
    endtask

    task automatic test_core1_first;
        launch(10);
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++; $display("FAIL relaunch_clears_done: got %b want 10", {busy, done});
        end
        tick();
        core_done = 2'b10; tick(); core_done = '0;
        checks++;
        if ({core_start, core_reset} !== 4'b01_10) begin
            errors++; $display("FAIL c1first_done: got %b want 0110", {core_start, core_reset});
        end
        tick();
        checks++;
        if (core_start !== 2'b11 || bid(1) != 2 || cnt(1) != exp_cnt(10, 2) || bid(0) != 0) begin
            errors++; $display("FAIL c1first_block2: start=%b id1=%0d cnt1=%0d id0=%0d want 11 2 2 0",
                               core_start, bid(1), cnt(1), bid(0));
        end
        core_done = 2'b11; tick(); core_done = '0;
        checks++;
        if ({core_start, core_reset, done} !== 5'b00_11_0) begin
            errors++; $display("FAIL c1first_last: got %b want 00110", {core_start, core_reset, done});
        end
        tick();
        checks++;
        if ({busy, done} !== 2'b01) begin
            errors++; $display("FAIL c1first_done_flag: got %b want 01", {busy, done});
        end
    endtask

    task automatic test_zero;
        launch(0);
        checks++;
        if ({core_start, core_reset, busy, done} !== 6'b00_11_1_0) begin
            errors++; $display("FAIL zero_launch: got %b want 001110", {core_start, core_reset, busy, done});
        end
        tick();
        checks++;
        if ({core_start, busy, done} !== 4'b00_1_0) begin
            errors++; $display("FAIL zero_run: got %b want 0010", {core_start, busy, done});
        end
        tick();
        checks++;
        if ({core_start, busy, done} !== 4'b00_0_1) begin
            errors++; $display("FAIL zero_done: got %b want 0001", {core_start, busy, done});
        end
    endtask

    task automatic test_simul_done;
        launch(12);
        tick();
        core_done = 2'b11; tick(); core_done = '0;
        checks++;
        if ({core_start, core_reset} !== 4'b00_11) begin
            errors++; $display("FAIL simul_pulse: got %b want 0011", {core_start, core_reset});
        end
        tick();
        checks++;
        if ({core_start, core_reset} !== 4'b01_00 || bid(0) != 2 || cnt(0) != exp_cnt(12, 2)) begin
            errors++; $display("FAIL simul_order: start=%b rst=%b id0=%0d cnt0=%0d want 01 00 2 4",
                               core_start, core_reset, bid(0), cnt(0));
        end
        core_done = 2'b10; tick(); core_done = '0;
        checks++;
        if ({core_start, core_reset, done} !== 5'b01_00_0) begin
            errors++; $display("FAIL idle_done_ignored: got %b want 01000", {core_start, core_reset, done});
        end
        core_done = 2'b01; tick(); core_done = '0;
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++; $display("FAIL simul_count: got %b want 10", {busy, done});
        end
        tick();
        checks++;
        if ({busy, done} !== 2'b01) begin
            errors++; $display("FAIL simul_done: got %b want 01", {busy, done});
        end
    endtask

    task automatic test_abort;
        launch(40);
        tick(); tick(); tick();
        abort = 1'b1; core_done = 2'b11; tick(); abort = 1'b0; core_done = '0;
        checks++;
        if ({core_start, core_reset, busy, done} !== 6'b00_11_0_0) begin
            errors++; $display("FAIL abort_now: got %b want 001100", {core_start, core_reset, busy, done});
        end
        tick();
        checks++;
        if ({core_start, core_reset, busy, done} !== 6'b00_00_0_0) begin
            errors++; $display("FAIL abort_idle: got %b want 000000", {core_start, core_reset, busy, done});
        end
        launch(4);
        checks++;
        if ({core_reset, busy} !== 3'b11_1) begin
            errors++; $display("FAIL abort_relaunch: got %b want 111", {core_reset, busy});
        end
        tick();
        checks++;
        if (core_start !== 2'b01 || bid(0) != 0 || cnt(0) != exp_cnt(4, 0)) begin
            errors++; $display("FAIL abort_relaunch_assign: start=%b id0=%0d cnt0=%0d want 01 0 4",
                               core_start, bid(0), cnt(0));
        end
        core_done = 2'b01; tick(); core_done = '0;
        tick();
        checks++;
        if ({busy, done} !== 2'b01) begin
            errors++; $display("FAIL abort_relaunch_done: got %b want 01", {busy, done});
        end
    endtask

    task automatic test_reset_midrun;
        launch(40);
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({core_start, core_reset, busy, done} !== 6'b00_11_0_0 ||
            {core_block_id, core_thread_count} !== '0) begin
            errors++; $display("FAIL async_reset: ctrl=%b data=%h want 001100 0",
                               {core_start, core_reset, busy, done}, {core_block_id, core_thread_count});
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({core_reset, busy} !== 3'b00_0) begin
            errors++; $display("FAIL async_release: got %b want 000", {core_reset, busy});
        end
        tick();
    endtask

    task automatic test_random;
        for (int r = 0; r < 8; r++) begin
            int tc, total, next_exp, completed;
            bit act [NC];
            bit pend [NC];
            int lat [NC];
            int seen [NC];
            bit finished, wait_done;
            tc = int'($urandom_range(1, 37));
            total = exp_blocks(tc);
            next_exp = 0; completed = 0; finished = 0; wait_done = 0;
            for (int i = 0; i < NC; i++) begin
                act[i] = 0; pend[i] = 0; lat[i] = 0; seen[i] = 0;
            end
            launch(tc);
            for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
                tick();
                if (wait_done) begin
                    checks++;
                    if ({core_start, busy, done} !== 4'b00_0_1 || next_exp != total) begin
                        errors++; $display("FAIL rand_done tc=%0d: got %b blocks=%0d want 0001 blocks=%0d",
                                           tc, {core_start, busy, done}, next_exp, total);
                    end
                    finished = 1;
                end else begin
                    checks++;
                    if ({busy, done} !== 2'b10) begin
                        errors++; $display("FAIL rand_busy tc=%0d: got %b want 10", tc, {busy, done});
                    end
                    for (int i = 0; i < NC; i++) begin
                        if (pend[i]) begin
                            checks++;
                            if ({core_start[i], core_reset[i]} !== 2'b01) begin
                                errors++; $display("FAIL rand_release tc=%0d core%0d: got %b want 01",
                                                   tc, i, {core_start[i], core_reset[i]});
                            end
                            act[i] = 0; pend[i] = 0; core_done[i] = 1'b0; completed++;
                        end
                    end
                    for (int i = 0; i < NC; i++) begin
                        if (!act[i] && core_start[i]) begin
                            checks++;
                            if (next_exp >= total || bid(i) != next_exp || cnt(i) != exp_cnt(tc, next_exp)) begin
                                errors++; $display("FAIL rand_assign tc=%0d core%0d: id=%0d cnt=%0d want id=%0d cnt=%0d",
                                                   tc, i, bid(i), cnt(i), next_exp, exp_cnt(tc, next_exp));
                            end
                            seen[i] = bid(i); act[i] = 1; next_exp++;
                            lat[i] = int'($urandom_range(0, 3));
                        end else if (act[i]) begin
                            checks++;
                            if (core_start[i] !== 1'b1 || bid(i) != seen[i]) begin
                                errors++; $display("FAIL rand_hold tc=%0d core%0d: start=%b id=%0d want 1 %0d",
                                                   tc, i, core_start[i], bid(i), seen[i]);
                            end
                        end
                    end
                    if (completed == total) wait_done = 1;
                    for (int i = 0; i < NC; i++) begin
                        if (act[i] && !pend[i]) begin
                            if (lat[i] == 0) begin
                                core_done[i] = 1'b1; pend[i] = 1;
                            end else begin
                                lat[i]--;
                            end
                        end
                    end
                end
            end
            checks++;
            if (!finished) begin
                errors++; $display("FAIL rand_timeout tc=%0d: completed=%0d want %0d", tc, completed, total);
                core_done = '0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_core1_first();
        test_zero();
        test_simul_done();
        test_abort();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
